// File: rtl/vga_line_fetcher.sv
// Row prefetcher for the VGA timing controller: bursts one 640-pixel row of
// 128-bit words into a line buffer and serves byte-swapped RGB565 pixels by h_counter.
module vga_line_fetcher #(
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned WORDS_PER_ROW = 80
) (
  input  logic              clk_25M,
  input  logic              rst_n,
  input  logic              start_frame,
  input  logic              start_row,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [9:0]        h_counter,
  output logic [15:0]       pixel_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [127:0]      rd_data,
  output logic              busy,
  output logic              underrun,
  output logic              fetch_late
);

  localparam int unsigned CNT_W   = $clog2(WORDS_PER_ROW + 1);
  localparam int unsigned IDX_W   = $clog2(WORDS_PER_ROW);
  localparam int unsigned ROW_W   = 9;
  localparam int unsigned ROWS    = 480;
  localparam int unsigned VISIBLE = 640;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  iss_cnt, iss_n;
  logic [CNT_W-1:0]  rx_cnt, rx_n;
  logic [ROW_W-1:0]  row_idx, row_idx_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic              late_n, under_n, buf_we;
  logic              visible;
  logic [IDX_W-1:0]  word_idx;
  logic [2:0]        lane;
  logic [7:0][15:0]  rd_word;
  logic [15:0]       lane_px, pixel_n;

  logic [127:0] line_buf [WORDS_PER_ROW];

  // Next-state, counters, row tracking, flags and pixel select
  always_comb begin
    state_n    = state;
    iss_n      = iss_cnt;
    rx_n       = rx_cnt;
    row_idx_n  = row_idx;
    row_base_n = row_base;
    late_n     = fetch_late;
    buf_we     = 1'b0;
    rd_word    = '0;

    if (start_row) begin
      if (state != S_IDLE) begin
        late_n = 1'b1;
      end else if (start_frame) begin
        row_idx_n  = '0;
        row_base_n = frame_base;
        iss_n      = '0;
        rx_n       = '0;
        state_n    = S_REQ;
      end else if (row_idx != ROW_W'(ROWS - 1)) begin
        row_idx_n  = row_idx + ROW_W'(1);
        row_base_n = row_base + ADDR_W'(WORDS_PER_ROW);
        iss_n      = '0;
        rx_n       = '0;
        state_n    = S_REQ;
      end
    end

    if (state == S_REQ && rd_req && rd_gnt) begin
      iss_n = iss_cnt + CNT_W'(1);
      if (iss_cnt == CNT_W'(WORDS_PER_ROW - 1)) state_n = S_WAIT;
    end

    // Returns are in order, so rx_cnt is both the write index and the fill level
    if (state != S_IDLE && rd_valid && rx_cnt < CNT_W'(WORDS_PER_ROW)) begin
      buf_we = 1'b1;
      rx_n   = rx_cnt + CNT_W'(1);
      if (state == S_WAIT && rx_cnt == CNT_W'(WORDS_PER_ROW - 1)) state_n = S_IDLE;
    end

    rd_addr_n = rd_addr;
    if (state_n == S_REQ) rd_addr_n = row_base_n + ADDR_W'(iss_n);

    visible  = (h_counter < 10'(VISIBLE));
    word_idx = IDX_W'(h_counter[9:3]);
    lane     = h_counter[2:0];
    if (visible) rd_word = line_buf[word_idx];
    // Lane 0 sits in the top 16 bits; the first memory byte goes to the low byte
    lane_px = rd_word[~lane];
    pixel_n = visible ? {lane_px[7:0], lane_px[15:8]} : 16'h0000;

    under_n = underrun |
              ((state != S_IDLE) && visible && (32'(h_counter[9:3]) >= 32'(rx_cnt)));
  end

  // State and output registers
  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      iss_cnt    <= '0;
      rx_cnt     <= '0;
      row_idx    <= '0;
      row_base   <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      pixel_data <= '0;
      underrun   <= 1'b0;
      fetch_late <= 1'b0;
    end else begin
      state      <= state_n;
      iss_cnt    <= iss_n;
      rx_cnt     <= rx_n;
      row_idx    <= row_idx_n;
      row_base   <= row_base_n;
      rd_req     <= (state_n == S_REQ);
      rd_addr    <= rd_addr_n;
      busy       <= (state_n != S_IDLE);
      pixel_data <= pixel_n;
      underrun   <= under_n;
      fetch_late <= late_n;
    end
  end

  // Line buffer storage (no reset needed)
  always_ff @(posedge clk_25M) begin
    if (rst_n && buf_we) line_buf[IDX_W'(rx_cnt)] <= rd_data;
  end

endmodule

// File: doc/vga_line_fetcher.md
# vga_line_fetcher

Line-fetch stage directly upstream of the VGA timing controller. On each row-start pulse it reads one 640-pixel row (80 × 128-bit words) of the current frame from memory into a line buffer. It serves 16-bit RGB565 pixels to the controller, indexed by the controller's horizontal counter, in the byte order the controller's colour decode expects. It also flags underrun and late-fetch conditions.

## Interface

- `ADDR_W`, 24: memory word-address width (one word = 128 bits).
- `WORDS_PER_ROW`, 80: words per row (640 px × 2 B / 16 B).
- `clk_25M`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start_frame`  in  1  one-cycle pulse; always coincides with a `start_row` pulse.
- `start_row`  in  1  one-cycle pulse; fetch the next row.
- `frame_base`  in  ADDR_W  word address of row 0; sampled on `start_frame`.
- `h_counter`  in  10  controller horizontal counter, 0..799.
- `pixel_data`  out  16  pixel for the `h_counter` value of the previous cycle.
- `rd_req`  out  1  memory read request.
- `rd_addr`  out  ADDR_W  request word address.
- `rd_gnt`  in  1  request accepted this cycle when `rd_req && rd_gnt`.
- `rd_valid`  in  1  read data valid. Returns are in request order, one word per pulse.
- `rd_data`  in  128  read data.
- `busy`  out  1  row fetch in progress.
- `underrun`  out  1  sticky: a displayed word was read before it arrived.
- `fetch_late`  out  1  sticky: `start_row` arrived while `busy`.

## Operation

- Line buffer: WORDS_PER_ROW × 128 bits, written at index `rx_cnt`.
- FSM states:
  - **IDLE**
    - `start_row` accepted when row slots remain (see row index rule).
    - Set `iss_cnt` = `rx_cnt` = 0, then go to REQ.
  - **REQ**
    - `rd_req` = 1, `rd_addr` = `row_base + iss_cnt`.
    - On grant: `iss_cnt++`.
    - On the grant with `iss_cnt == WORDS_PER_ROW-1`: go to WAIT.
  - **WAIT**
    - `rd_req` = 0.
    - When the `rd_valid` that makes `rx_cnt == WORDS_PER_ROW` arrives: go to IDLE.
- `rd_valid` is accepted in both REQ and WAIT. Each beat writes `buf[rx_cnt]` and does `rx_cnt++`.
- `busy` = (state != IDLE).
- `rd_req`/`rd_addr` are stable while ungranted. No address is issued twice.
- Row index:
  - `start_frame`: latch `frame_base`, set `row_idx` = 0, `row_base` = `frame_base`.
  - Otherwise `start_row` does `row_idx++` and `row_base += WORDS_PER_ROW`.
  - `start_row` without `start_frame` when `row_idx == 479`: ignored, no fetch.
- `start_row` (with or without `start_frame`) while `busy`:
  - The pulse is ignored entirely; row index and base are unchanged.
  - `fetch_late` is set.
  - The current fetch completes normally.
- Pixel select:
  - Word = `h_counter[9:3]`, lane `l` = `h_counter[2:0]`.
  - `pixel_data[7:0]` = `word[127-16l -: 8]`.
  - `pixel_data[15:8]` = `word[119-16l -: 8]`.
  - The first memory byte of a pixel therefore lands in the low byte.
- When `h_counter >= 640`: `pixel_data` = 0.
- Underrun: `underrun` is set when `busy && h_counter < 640 && h_counter[9:3] >= rx_cnt`. Stale buffer contents are output in that case.
- `underrun` and `fetch_late` clear only on reset.
- `rd_valid` while IDLE is ignored; no write, no flag.

## Timing

- Reset values:
  - Outputs: `rd_req` 0, `rd_addr` 0, `pixel_data` 0, `busy` 0, `underrun` 0, `fetch_late` 0.
  - Internal: state IDLE, `row_idx` 0, `row_base` 0, counters 0.
- `start_row` in cycle t → `rd_req` = 1 with the first address in t+1.
- With `rd_gnt` held high, the 80 requests are issued in cycles t+1..t+80.
- `pixel_data` is registered, with 1-cycle latency from `h_counter`.
- A buffer write by `rd_valid` in cycle t is visible to a pixel read of that word from cycle t+1.
- Budget: the controller pulses at h=640, and display of the row starts 160 cycles later. Word w must arrive before cycle 160+8w after the pulse, otherwise `underrun` is set.
- Reset asserted mid-fetch: state returns to IDLE the next cycle. `rd_req` drops and the in-flight returns are ignored.

## Test plan

1. **Reset.** Hold `rst_n` = 0 with random inputs → all outputs 0. After release, no `rd_req` until `start_row`.
2. **Row 0 fetch.**
   - Stimulus: `start_frame` + `start_row` with `frame_base` = 0x001000; `rd_gnt` = 1; `rd_valid` 2 cycles after each grant.
   - Required: `rd_addr` 0x001000..0x00104F in 80 consecutive cycles; `busy` falls after the 80th `rd_valid`; `underrun` = 0.
3. **Byte order.**
   - Stimulus: word 0 = 0x00112233_44556677_8899AABB_CCDDEEFF.
   - Required: h=0 → 0x1100; h=1 → 0x3322; h=7 → 0xFFEE; h=640 → 0x0000.
4. **Row advance.** A 2nd `start_row` gives first address 0x001050; the 3rd gives 0x0010A0. A new `start_frame` with base 0x002000 restarts at 0x002000.
5. **Backpressure.** `rd_gnt` alternates 0/1 → the address holds while ungranted; exactly 80 unique addresses are issued over 160 cycles.
6. **Error flags.**
   - `rd_valid` for word 0 delayed 200 cycles past the pulse, while `h_counter` sweeps from 0 → `underrun` = 1.
   - `start_row` during `busy` → `fetch_late` = 1, no extra requests, `row_idx` unchanged.
